fft_bin_display: RTL and testbench
==================================

Name: fft_bin_display

Overview:
- Output-side reader for the FFT datapath on the DE0 board: fetches one complex bin from the FFT result buffer and shows its approximate magnitude on the 8 user LEDs.
- Slide switches select the bin, the display scale and manual/scan mode.
- Sits between the FFT core's result-buffer read port and the board LED pins.
- Complements the switch-driven sample/control input path.

Parameters:
- N_BINS, 8, number of FFT output bins (power of 2, ≤ 8).
- ADDR_W, 3, bin address width, log2(N_BINS).
- DW, 16, signed two's-complement width of rd_re and rd_im.
- BASE_SHIFT, 5, fixed right shift applied before the switch-selected shift.
- SCAN_DIV, 25000000, clocks per bin in scan mode (0.5 s at 50 MHz); must be ≥ 2.

Ports:
- clk  in  1  50 MHz board clock.
- reset  in  1  synchronous, active-high reset.
- SW  in  8  raw slide switches, asynchronous. SW[7] selects scan mode; SW[6:4] is the extra shift; SW[3] is reserved; SW[ADDR_W-1:0] is the manual bin.
- result_valid  in  1  level signal, high while the FFT result buffer holds a complete frame.
- rd_req  out  1  read request to the result buffer.
- rd_addr  out  ADDR_W  bin address; stable while rd_req is high.
- rd_ack  in  1  buffer accepts the request; rd_re and rd_im are valid in the same cycle.
- rd_re  in  DW  real part of the bin.
- rd_im  in  DW  imaginary part of the bin.
- LED  out  8  display value.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Clears LED, rd_req, rd_addr, busy, the synchronizer flops, the pending flag, the prescaler and the scan index; state goes to IDLE.
  - Reset asserted mid-read drops rd_req at the same edge; no LED update occurs.
- SW synchronizer: two-flop, giving sw_s. A sw_s change is detected by comparing against a third registered copy.
- Triggers (each sets the pending flag):
  - (a) rising edge of result_valid;
  - (b) any sw_s change while result_valid is high;
  - (c) scan-mode prescaler terminal count.
  - Triggers arriving while busy merge into the single pending flag, which is serviced on return to IDLE. At most one extra read occurs.
- Bin index:
  - Manual mode (sw_s[7]=0): index = sw_s[ADDR_W-1:0].
  - Scan mode:
    - The prescaler counts 0..SCAN_DIV-1 only while result_valid is high.
    - At terminal count the prescaler returns to 0 and scan index becomes (scan index + 1) mod N_BINS (wraps N_BINS-1 → 0), with a trigger.
    - Entering or leaving scan mode zeroes both the prescaler and the scan index.
- FSM:
  - IDLE:
    - If pending and result_valid: clear pending, latch index into rd_addr, go to REQ.
    - If pending while result_valid is low: the flag is discarded.
  - REQ: rd_req=1; wait indefinitely. On a cycle with rd_req & rd_ack, capture rd_re/rd_im and go to CALC.
  - CALC:
    - a = |re|, b = |im|; |−2^(DW−1)| saturates to 2^(DW−1)−1.
    - mag = max(a,b) + (min(a,b) >> 1), computed at DW+1 bits unsigned, no overflow possible.
    - s = mag >> (BASE_SHIFT + sw_s[6:4]).
    - Manual mode: LED = (s > 255) ? 255 : s.
    - Scan mode: LED[7:5] = rd_addr (zero-extended when ADDR_W < 3); LED[4:0] = min(s, 31).
    - Go to IDLE.
- Latency: trigger registered in cycle T → rd_req high in T+1. If rd_ack is high in T+1, LED shows the new value from T+3.
- result_valid falling: LED holds its last value. An in-flight read completes normally.
- rd_req is never asserted while result_valid is low at IDLE exit. rd_addr never changes during REQ.

Test Plan:
- Reset, then result_valid=1, SW=8'h03, buffer bin3 = (re=1000, im=−400), rd_ack tied high → rd_req 1 cycle at rd_addr=3; mag=1200, shift 5 → LED=37 (8'h25) four cycles after the result_valid edge.
- SW=8'h70 (shift 12), bin0 = (−32768, −32768) → a=b=32767, mag=49150, LED=11. With SW=8'h00 (shift 5): 49150>>5 = 1535, saturates → LED=255.
- rd_ack held low 10 cycles → rd_req and rd_addr stable throughout, busy=1, LED unchanged; switch SW[2:0] to 5 mid-wait → exactly one follow-up read at addr 5 after return to IDLE.
- Scan mode with SCAN_DIV=4, all bins re=32·k, im=0 → rd_addr sequence 1,2,…,7,0,1 every 4 cycles; LED[7:5]=index, LED[4:0]=index (k>>0 after shift 5).
- result_valid low with SW toggling → no rd_req, LED holds its value. Then raise result_valid → single read at the current SW bin.
- Assert reset during REQ → rd_req=0, LED=0 and busy=0 after the reset edge; no capture even if rd_ack is high on that edge.

Source files
------------

// File: rtl/fft_bin_display.sv
// Reads one complex bin from the FFT result buffer and shows an approximate
// magnitude (max + min/2) on the board LEDs, manually selected or auto-scanned.
module fft_bin_display #(
  parameter int N_BINS     = 8,
  parameter int ADDR_W     = 3,
  parameter int DW         = 16,
  parameter int BASE_SHIFT = 5,
  parameter int SCAN_DIV   = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        SW,
  input  logic              result_valid,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DW-1:0]     rd_re,
  input  logic [DW-1:0]     rd_im,
  output logic [7:0]        LED,
  output logic              busy
);
  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, REQ, CALC} state_t;

  function automatic logic [DW-1:0] sat_abs(input logic signed [DW-1:0] x);
    logic [DW-1:0] r;
    if (x == {1'b1, {(DW-1){1'b0}}}) r = {1'b0, {(DW-1){1'b1}}};
    else if (x < 0)                  r = $unsigned(-x);
    else                             r = $unsigned(x);
    return r;
  endfunction

  function automatic logic [7:0] sat8(input logic [DW:0] v);
    return (v > (DW+1)'(255)) ? 8'hff : v[7:0];
  endfunction

  function automatic logic [4:0] sat5(input logic [DW:0] v);
    return (v > (DW+1)'(31)) ? 5'h1f : v[4:0];
  endfunction

  state_t               state, state_n;
  logic [7:0]           sw_m, sw_s, sw_d;
  logic                 rv_d, pending, scan, tc, trig, issue, cap;
  logic [PW-1:0]        presc;
  logic [ADDR_W-1:0]    scan_idx, idx;
  logic signed [DW-1:0] re_p1, im_p1;
  logic [DW-1:0]        a_p1, b_p1, mx_p1, mn_p1;
  logic [DW:0]          mag_p1, s_p1;
  int                   sh;

  assign scan  = sw_s[7];
  assign tc    = scan && result_valid && (presc == PW'(SCAN_DIV - 1));
  assign trig  = (result_valid && !rv_d) || (result_valid && (sw_s != sw_d)) || tc;
  assign idx   = scan ? scan_idx : sw_s[ADDR_W-1:0];
  assign issue = (state == IDLE) && pending && result_valid;
  assign cap   = (state == REQ) && rd_ack && !reset;
  assign rd_req = (state == REQ);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pending && result_valid) state_n = REQ;
      REQ:     if (rd_ack) state_n = CALC;
      CALC:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control: switch sync, trigger merging, scan prescaler, address and LED
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_m     <= '0;
      sw_s     <= '0;
      sw_d     <= '0;
      rv_d     <= 1'b0;
      pending  <= 1'b0;
      presc    <= '0;
      scan_idx <= '0;
      rd_addr  <= '0;
      LED      <= '0;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
      sw_d <= sw_s;
      rv_d <= result_valid;
      // IDLE always consumes the flag: serviced when valid, dropped otherwise
      pending <= trig || (pending && (state != IDLE));
      if (scan != sw_d[7]) begin
        presc    <= '0;
        scan_idx <= '0;
      end else if (tc) begin
        presc    <= '0;
        scan_idx <= (scan_idx == ADDR_W'(N_BINS - 1)) ? '0 : scan_idx + 1'b1;
      end else if (scan && result_valid) begin
        presc <= presc + 1'b1;
      end
      if (issue) rd_addr <= idx;
      if (state == CALC) LED <= scan ? {3'(rd_addr), sat5(s_p1)} : sat8(s_p1);
    end
  end

  // p1: captured bin, consumed in CALC
  always_ff @(posedge clk) begin
    if (cap) begin
      re_p1 <= rd_re;
      im_p1 <= rd_im;
    end
  end

  always_comb begin
    a_p1   = sat_abs(re_p1);
    b_p1   = sat_abs(im_p1);
    mx_p1  = (a_p1 > b_p1) ? a_p1 : b_p1;
    mn_p1  = (a_p1 > b_p1) ? b_p1 : a_p1;
    mag_p1 = {1'b0, mx_p1} + {2'b00, mn_p1[DW-1:1]};
    sh     = BASE_SHIFT + int'(sw_s[6:4]);
    s_p1   = mag_p1 >> sh;
  end
endmodule

// File: tb/tb_fft_bin_display.sv
// Directed bench for fft_bin_display: stimulus pushes expected reads into a
// scoreboard queue; a negedge monitor checks address and resulting LED value.
module tb_fft_bin_display;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  SW;
  logic        result_valid;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ack;
  logic [15:0] rd_re, rd_im;
  logic [7:0]  LED;
  logic        busy;

  logic              ack_en;
  logic signed [15:0] mem_re [8];
  logic signed [15:0] mem_im [8];

  typedef struct {
    logic [2:0] addr;
    logic [7:0] led;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_ack = ack_en;
  assign rd_re  = mem_re[rd_addr];
  assign rd_im  = mem_im[rd_addr];

  fft_bin_display #(
    .N_BINS(8), .ADDR_W(3), .DW(16), .BASE_SHIFT(5), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .SW(SW), .result_valid(result_valid),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_re(rd_re), .rd_im(rd_im), .LED(LED), .busy(busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_read(input logic [2:0] a, input logic [7:0] l);
    exp_t e;
    e.addr = a;
    e.led  = l;
    exp_q.push_back(e);
  endtask

  // Monitor: each accepted read is checked for address, then its LED two edges later
  initial begin : monitor
    int cd;
    logic [7:0] led_want;
    exp_t e;
    cd = 0;
    led_want = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) check("led_after_read", 16'(LED), 16'(led_want));
        end
        if (rd_req && rd_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got addr %0d, expected no read at %0t", rd_addr, $time);
          end else begin
            e = exp_q.pop_front();
            check("rd_addr", 16'(rd_addr), 16'(e.addr));
            led_want = e.led;
            cd = 2;
          end
        end
      end
    end
  end

  initial begin : stimulus
    for (int k = 0; k < 8; k++) begin
      mem_re[k] = '0;
      mem_im[k] = '0;
    end
    reset = 1'b1;
    SW = 8'h00;
    result_valid = 1'b0;
    ack_en = 1'b1;
    tick(3);
    check("reset_led", 16'(LED), 16'd0);
    check("reset_rd_req", 16'(rd_req), 16'd0);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_rd_addr", 16'(rd_addr), 16'd0);
    reset = 1'b0;

    // Basic read: bin3 = (1000, -400) -> mag 1200 >> 5 = 37
    mem_re[3] = 16'sd1000;
    mem_im[3] = -16'sd400;
    SW = 8'h03;
    tick(4);
    check("no_req_while_invalid", 16'(rd_req), 16'd0);
    expect_read(3'd3, 8'd37);
    result_valid = 1'b1;
    tick(2);
    check("t1_rd_req", 16'(rd_req), 16'd1);
    check("t1_rd_addr", 16'(rd_addr), 16'd3);
    tick(2);
    check("t1_led", 16'(LED), 16'h25);
    check("t1_busy_idle", 16'(busy), 16'd0);

    // Most-negative bin: a=b=32767, mag 49150
    mem_re[0] = -16'sd32768;
    mem_im[0] = -16'sd32768;
    expect_read(3'd0, 8'd11);
    SW = 8'h70;
    tick(8);
    check("t2_led_shift12", 16'(LED), 16'd11);
    expect_read(3'd0, 8'd255);
    SW = 8'h00;
    tick(8);
    check("t2_led_sat", 16'(LED), 16'd255);

    // Stalled ack with a bin change mid-wait
    mem_re[1] = 16'sd320;
    mem_im[1] = 16'sd0;
    mem_re[5] = 16'sd0;
    mem_im[5] = -16'sd640;
    ack_en = 1'b0;
    expect_read(3'd1, 8'd10);
    SW = 8'h01;
    tick(5);
    for (int i = 0; i < 10; i++) begin
      check("stall_rd_req", 16'(rd_req), 16'd1);
      check("stall_rd_addr", 16'(rd_addr), 16'd1);
      check("stall_busy", 16'(busy), 16'd1);
      check("stall_led", 16'(LED), 16'd255);
      if (i == 3) begin
        expect_read(3'd5, 8'd20);
        SW = 8'h05;
      end
      tick(1);
    end
    ack_en = 1'b1;
    tick(10);
    check("t3_led_followup", 16'(LED), 16'd20);

    // Switches toggling with no valid frame: no reads, LED holds
    result_valid = 1'b0;
    mem_re[7] = 16'sd224;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) SW = 8'h02;
      if (i == 4) SW = 8'h06;
      if (i == 8) SW = 8'h07;
      tick(1);
      check("invalid_no_req", 16'(rd_req), 16'd0);
    end
    check("invalid_led_hold", 16'(LED), 16'd20);
    expect_read(3'd7, 8'd7);
    result_valid = 1'b1;
    tick(6);
    check("t5_led", 16'(LED), 16'd7);

    // Scan mode: bin k = (32k, 0) -> LED = {k, k}
    for (int k = 0; k < 8; k++) begin
      mem_re[k] = 16'(32 * k);
      mem_im[k] = 16'sd0;
    end
    expect_read(3'd0, 8'd0);
    for (int j = 1; j <= 9; j++) expect_read(3'(j % 8), 8'(33 * (j % 8)));
    SW = 8'h80;
    tick(40);
    result_valid = 1'b0;
    tick(4);
    check("scan_last_led", 16'(LED), 16'd33);
    check("scan_idle", 16'(busy), 16'd0);
    SW = 8'h00;
    tick(4);

    // Reset while waiting in REQ
    mem_re[0] = 16'sd32000;
    ack_en = 1'b0;
    result_valid = 1'b1;
    tick(3);
    check("t6_in_req", 16'(rd_req), 16'd1);
    reset = 1'b1;
    ack_en = 1'b1;
    result_valid = 1'b0;
    tick(1);
    check("t6_rd_req_dropped", 16'(rd_req), 16'd0);
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_led", 16'(LED), 16'd0);
    reset = 1'b0;
    tick(5);
    check("t6_led_after", 16'(LED), 16'd0);
    check("t6_no_req", 16'(rd_req), 16'd0);

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
